result_router: RTL and testbench
================================

Name: result_router

Overview:
- Inverse of the 2:1 result select path. Takes a single 32-bit result stream from the determinant datapath and steers each word, by a per-word select bit, into one of two buffered output channels (A when sel=0, B when sel=1).
- Each channel has its own small first-word-fall-through FIFO with valid/ready handshake, so the two consumers stall independently.
- Sits between the determinant datapath result bus and the downstream consumers (accumulator / output register stage).

Parameters:
- WIDTH, 32, result word width.
- DEPTH, 4, entries per channel FIFO. Must be a power of 2 and at least 2.
- CW, $clog2(DEPTH)+1, occupancy count width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of both FIFOs.
- in_valid  input  1  input word valid.
- in_ready  output  1  router can accept the word on the selected channel.
- in_sel  input  1  destination: 0 = channel A, 1 = channel B.
- in_data  input  WIDTH  result word.
- a_valid  output  1  channel A head word valid.
- a_ready  input  1  channel A consumer accepts.
- a_data  output  WIDTH  channel A head word.
- b_valid  output  1  channel B head word valid.
- b_ready  input  1  channel B consumer accepts.
- b_data  output  WIDTH  channel B head word.
- a_count  output  CW  channel A occupancy.
- b_count  output  CW  channel B occupancy.

Behaviour:
- Single clock, clk. rst is asynchronous and active-high.
- Reset state: both FIFOs empty, pointers 0. in_ready=1, a_valid=b_valid=0, a_count=b_count=0. a_data and b_data are 0 (storage cleared).
- in_ready is combinational: in_ready = in_sel ? ~full_b : ~full_a. It depends on in_sel, never on in_valid.
- Write: on in_valid & in_ready, in_data is written to the selected FIFO at its write pointer, and that pointer increments modulo DEPTH.
- Read: on x_valid & x_ready, channel x read pointer increments modulo DEPTH.
- x_valid = (x_count != 0). x_data always presents mem[rd_ptr], which gives first-word fall-through.
- Latency: a word accepted at edge N is visible as x_valid=1 after edge N (one cycle). There is no combinational pass-through from in_data to x_data.
- Pointers are log2(DEPTH) bits, wrap naturally. Full/empty are tracked by the count, not by pointer compare.
- Simultaneous write and read on the same channel: count is unchanged, both pointers advance. This is legal when the channel is full only if the read happens. Even so, in_ready is 0 when full: no same-cycle pass-through on a full FIFO.
- Simultaneous write to one channel and read from the other: fully independent.
- Read while empty: ignored (x_valid=0), pointers hold.
- Write attempted while the selected FIFO is full: in_ready=0, the word is not taken, and the upstream must hold in_data and in_sel stable.
- flush=1 at a clock edge: both counts and pointers go to 0. Any concurrent write or read in that cycle is discarded. flush has priority over all handshakes.
- rst asserted mid-transfer: immediate return to the reset state and in-flight data is lost. After rst deassertion the block accepts on the first edge.
- Count arithmetic: x_count_next = x_count + wr_x - rd_x, in CW bits. It never exceeds DEPTH by construction.

Decomposition:
- Shared package (determinant_pkg): RESULT_WIDTH = 32, and the SEL_A = 1'b0 / SEL_B = 1'b1 destination constants. These are shared with the result select mux.
- One sub-module, result_fifo: a parameterised FWFT FIFO (WIDTH, DEPTH) with wr_en, rd_en, flush, full, empty and count. It is instantiated twice.
- result_router itself holds only the steering logic and the in_ready mux.

Test Plan:
- Reset then idle: assert rst for 3 cycles → in_ready=1, a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=0.
- Steering: send 0x0000_0011 (sel=0) then 0x0000_0022 (sel=1), with a_ready=b_ready=1 → a_data=0x11 and b_data=0x22, each valid exactly one cycle after its acceptance; order preserved.
- Full/backpressure: a_ready=0, push 4 words 0xA0..0xA3 to A → a_count=4. A 5th write with sel=0 sees in_ready=0 while in_ready=1 for sel=1. Then a_ready=1 → pops 0xA0..0xA3 in order.
- Wrap-around: with DEPTH=4, stream 10 words 1..10 to B while b_ready toggles 1/0 each cycle → output sequence is exactly 1..10 with no loss or duplication, and b_count never exceeds 4.
- Simultaneous read and write: with A holding 2 words, write 0x55 to A while popping A in the same cycle → a_count stays 2 and 0x55 exits third.
- Flush and async reset mid-stream: with A=3 and B=2 entries, pulse flush → next cycle both counts are 0 and valids are 0. Refill, then assert rst between edges → outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/determinant_pkg.sv
// Constants shared by the determinant result path: word width and
// the 2:1 destination encoding used by both the select mux and the router.
package determinant_pkg;

    localparam int unsigned RESULT_WIDTH = 32;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef logic [RESULT_WIDTH-1:0] result_t;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO for one router channel. Occupancy is tracked
// by count, so pointers are free-running log2(DEPTH)-bit indices.
module result_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and count; flush drops any same-cycle handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_fire) - CW'(rd_fire);
        end
    end

endmodule

// File: rtl/result_router.sv
// Steers the single determinant result stream into two independently
// back-pressured FWFT channels, A (sel=0) and B (sel=1).
module result_router
    import determinant_pkg::*;
#(
    parameter  int unsigned WIDTH = RESULT_WIDTH,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CW-1:0]    a_count,
    output logic [CW-1:0]    b_count
);

    logic full_a;
    logic full_b;
    logic empty_a;
    logic empty_b;
    logic wr_a;
    logic wr_b;

    // Ready follows the selected channel only, never in_valid.
    assign in_ready = (in_sel == SEL_B) ? ~full_b : ~full_a;
    assign wr_a     = in_valid & in_ready & (in_sel == SEL_A);
    assign wr_b     = in_valid & in_ready & (in_sel == SEL_B);
    assign a_valid  = ~empty_a;
    assign b_valid  = ~empty_b;

    result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_a),
        .wr_data (in_data),
        .rd_en   (a_ready),
        .full    (full_a),
        .empty   (empty_a),
        .count   (a_count),
        .rd_data (a_data)
    );

    result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_b),
        .wr_data (in_data),
        .rd_en   (b_ready),
        .full    (full_b),
        .empty   (empty_b),
        .count   (b_count),
        .rd_data (b_data)
    );

endmodule

// File: tb/tb_result_router.sv
// Self-checking bench for result_router: queue-based channel model,
// per-cycle output compare, directed scenarios and randomized traffic.
module tb_result_router;
    import determinant_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             flush    = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sel   = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic             a_ready  = 1'b0;
    logic             b_ready  = 1'b0;
    logic             in_ready;
    logic             a_valid;
    logic             b_valid;
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic [CW-1:0]    a_count;
    logic [CW-1:0]    b_count;

    int nvec = 0;
    int nerr = 0;

    // Model state: contents of each channel, oldest first.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    bit               m_acc;
    bit               m_pa;
    bit               m_pb;

    // Words observed leaving the DUT, and peak B occupancy seen.
    logic [WIDTH-1:0] log_a[$];
    logic [WIDTH-1:0] log_b[$];
    logic             pa_valid = 1'b0;
    logic             pb_valid = 1'b0;
    logic [WIDTH-1:0] pa_data  = '0;
    logic [WIDTH-1:0] pb_data  = '0;
    int               max_b    = 0;

    result_router #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per edge, at most one push and one pop per channel.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            m_acc = in_valid && (in_sel ? (qb.size() < int'(DEPTH)) : (qa.size() < int'(DEPTH)));
            m_pa  = a_ready && (qa.size() > 0);
            m_pb  = b_ready && (qb.size() > 0);
            if (m_pa) void'(qa.pop_front());
            if (m_pb) void'(qb.pop_front());
            if (m_acc) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        chk("a_valid", 64'(a_valid), 64'(qa.size() != 0));
        chk("b_valid", 64'(b_valid), 64'(qb.size() != 0));
        chk("a_count", 64'(a_count), 64'(qa.size()));
        chk("b_count", 64'(b_count), 64'(qb.size()));
        if (qa.size() != 0) chk("a_data", 64'(a_data), 64'(qa[0]));
        if (qb.size() != 0) chk("b_data", 64'(b_data), 64'(qb[0]));
        chk("in_ready", 64'(in_ready),
            64'(in_sel ? (qb.size() < int'(DEPTH)) : (qa.size() < int'(DEPTH))));
        // Handshake inputs now held are the ones sampled at the last rising edge.
        if (!rst && !flush) begin
            if (pa_valid && a_ready) log_a.push_back(pa_data);
            if (pb_valid && b_ready) log_b.push_back(pb_data);
        end
        pa_valid = a_valid;
        pa_data  = a_data;
        pb_valid = b_valid;
        pb_data  = b_data;
        if (int'(b_count) > max_b) max_b = int'(b_count);
    end

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic ar, input logic br, input logic fl);
        @(negedge clk);
        #1;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        flush    = fl;
        #1;
    endtask

    initial begin
        int k;
        int cyc;
        bit pending;
        logic v;
        logic s;
        logic [WIDTH-1:0] d;
        int rp;

        // Reset then idle
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_a_valid",  64'(a_valid),  64'd0);
        chk("reset_b_valid",  64'(b_valid),  64'd0);
        chk("reset_a_count",  64'(a_count),  64'd0);
        chk("reset_b_count",  64'(b_count),  64'd0);
        chk("reset_a_data",   64'(a_data),   64'd0);
        chk("reset_b_data",   64'(b_data),   64'd0);
        rst = 1'b0;

        // Steering with one-cycle latency
        drive(1'b1, SEL_A, 32'h11, 1'b1, 1'b1, 1'b0);
        chk("steer_a_not_yet", 64'(a_valid), 64'd0);
        drive(1'b1, SEL_B, 32'h22, 1'b1, 1'b1, 1'b0);
        chk("steer_a_valid", 64'(a_valid), 64'd1);
        chk("steer_a_data",  64'(a_data),  64'h11);
        chk("steer_b_not_yet", 64'(b_valid), 64'd0);
        drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("steer_a_gone",  64'(a_valid), 64'd0);
        chk("steer_b_valid", 64'(b_valid), 64'd1);
        chk("steer_b_data",  64'(b_data),  64'h22);
        drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("steer_b_gone",  64'(b_valid), 64'd0);

        // Full channel A and backpressure
        for (int i = 0; i < 4; i++) drive(1'b1, SEL_A, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, SEL_A, 32'hA4, 1'b0, 1'b0, 1'b0);
        chk("full_a_count",    64'(a_count),  64'd4);
        chk("full_in_ready_a", 64'(in_ready), 64'd0);
        in_sel = SEL_B;
        #1;
        chk("full_in_ready_b", 64'(in_ready), 64'd1);
        in_sel = SEL_A;
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("full_pop_order", 64'(a_data), 64'h0A0 + 64'(i));
        end
        drive(1'b0, SEL_A, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("full_drained", 64'(a_valid), 64'd0);

        // Wrap-around on B with toggling ready
        log_b.delete();
        max_b = 0;
        k = 1;
        cyc = 0;
        while (k <= 10 && cyc < 100) begin
            drive(1'b1, SEL_B, 32'(k), 1'b0, (cyc % 2 == 0), 1'b0);
            if (in_ready) k++;
            cyc++;
        end
        chk("wrap_all_accepted", 64'(k), 64'd11);
        for (int i = 0; i < 12; i++) drive(1'b0, SEL_B, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("wrap_out_len", 64'(log_b.size()), 64'd10);
        for (int i = 0; i < 10 && i < log_b.size(); i++)
            chk("wrap_out_word", 64'(log_b[i]), 64'(i + 1));
        chk("wrap_max_count_le_depth", 64'(max_b <= int'(DEPTH)), 64'd1);

        // Simultaneous write and read on A
        drive(1'b0, SEL_A, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, SEL_A, 32'h1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, SEL_A, 32'h2, 1'b0, 1'b0, 1'b0);
        log_a.delete();
        drive(1'b1, SEL_A, 32'h55, 1'b1, 1'b0, 1'b0);
        chk("simul_pre_count", 64'(a_count), 64'd2);
        drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("simul_count_held", 64'(a_count), 64'd2);
        for (int i = 0; i < 3; i++) drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, SEL_A, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("simul_out_len", 64'(log_a.size()), 64'd3);
        if (log_a.size() == 3) begin
            chk("simul_out0", 64'(log_a[0]), 64'h1);
            chk("simul_out1", 64'(log_a[1]), 64'h2);
            chk("simul_out2", 64'(log_a[2]), 64'h55);
        end

        // Flush mid-stream, then async reset between edges
        for (int i = 0; i < 3; i++) drive(1'b1, SEL_A, 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, SEL_B, 32'hD0 + 32'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, SEL_A, 32'hEE, 1'b1, 1'b1, 1'b1);
        chk("flush_pre_a_count", 64'(a_count), 64'd3);
        chk("flush_pre_b_count", 64'(b_count), 64'd2);
        drive(1'b0, SEL_A, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("flush_a_count", 64'(a_count), 64'd0);
        chk("flush_b_count", 64'(b_count), 64'd0);
        chk("flush_a_valid", 64'(a_valid), 64'd0);
        chk("flush_b_valid", 64'(b_valid), 64'd0);
        drive(1'b1, SEL_A, 32'h77, 1'b0, 1'b0, 1'b0);
        drive(1'b1, SEL_B, 32'h88, 1'b0, 1'b0, 1'b0);
        drive(1'b0, SEL_A, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("refill_a_valid", 64'(a_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_a_valid",  64'(a_valid),  64'd0);
        chk("arst_b_valid",  64'(b_valid),  64'd0);
        chk("arst_a_count",  64'(a_count),  64'd0);
        chk("arst_b_count",  64'(b_count),  64'd0);
        chk("arst_a_data",   64'(a_data),   64'd0);
        chk("arst_b_data",   64'(b_data),   64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, SEL_A, 32'h99, 1'b0, 1'b0, 1'b0);
        drive(1'b0, SEL_A, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_a_valid", 64'(a_valid), 64'd1);
        chk("post_rst_a_data",  64'(a_data),  64'h99);

        // Randomized traffic; a refused word is held stable until taken
        pending = 1'b0;
        v = 1'b0;
        s = 1'b0;
        d = '0;
        for (int n = 0; n < 3000; n++) begin
            case ((n / 500) % 6)
                0: rp = 90;
                1: rp = 50;
                2: rp = 10;
                3: rp = 70;
                4: rp = 30;
                default: rp = 100;
            endcase
            if (!pending) begin
                v = ($urandom_range(0, 9) < 7);
                s = 1'($urandom_range(0, 1));
                d = $urandom;
            end
            drive(v, s, d,
                  ($urandom_range(0, 99) < rp),
                  ($urandom_range(0, 99) < (110 - rp)),
                  ($urandom_range(0, 99) == 0));
            pending = in_valid && !in_ready;
            if (n == 1500) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                pending = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
